// File: rtl/mdu_seq_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer.
// Optional early-out paths are enabled by defining MDU_EARLY_OUT_EN.
package mdu_seq_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 5;

    // RV32M funct3 encodings
    localparam logic [2:0] MDU_MUL    = 3'b000;
    localparam logic [2:0] MDU_MULH   = 3'b001;
    localparam logic [2:0] MDU_MULHSU = 3'b010;
    localparam logic [2:0] MDU_MULHU  = 3'b011;
    localparam logic [2:0] MDU_DIV    = 3'b100;
    localparam logic [2:0] MDU_DIVU   = 3'b101;
    localparam logic [2:0] MDU_REM    = 3'b110;
    localparam logic [2:0] MDU_REMU   = 3'b111;

    // Final iteration index of the CALC phase
    localparam logic [CNT_W-1:0] MDU_LAST_CNT = 5'd31;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'b00,
        MDU_CALC = 2'b01,
        MDU_FIX  = 2'b10,
        MDU_DONE = 2'b11
    } mdu_state_e;

    // Magnitude of a value that is treated as signed only when is_signed is set
    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] value,
                                                  input logic            is_signed);
        return (is_signed && value[XLEN-1]) ? (~value + 1'b1) : value;
    endfunction

endpackage

// File: rtl/mdu_seq_addsub33.sv
// Combinational 33-bit adder/subtractor shared by the multiply and divide steps.
// carry=1 on a subtract means no borrow (a >= b).
module mdu_seq_addsub33 (
    input  logic [32:0] a,
    input  logic [32:0] b,
    input  logic        sub,
    output logic [32:0] sum,
    output logic        carry
);

    assign {carry, sum} = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {33'd0, sub};

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle RV32M multiply/divide sequencer: one bit per cycle over 32 CALC
// cycles, a sign fix-up cycle, then a one-cycle done pulse.
// Optional feature macro: MDU_EARLY_OUT_EN (trivial operands finish in IDLE).
module mdu_seq
    import mdu_seq_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic [XLEN-1:0] C,
    output logic            busy,
    output logic            done,
    output logic            stall
);

    mdu_state_e        state, next_state;
    logic [2:0]        op;
    logic [CNT_W-1:0]  cnt;
    logic [XLEN-1:0]   mb;       // divisor / multiplicand magnitude
    logic [XLEN-1:0]   hi;       // product high half, or partial remainder
    logic [XLEN-1:0]   lo;       // product low half / multiplier, or dividend->quotient
    logic              neg_res;  // negate the selected result in FIX

    logic              sign_a, sign_b;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              div_zero, div_ovf, early, special;
    logic [XLEN-1:0]   special_c, fix_c;
    logic [32:0]       add_a, add_b, add_sum;
    logic              add_sub, add_carry;

    // Operand sign handling at acceptance
    assign sign_a = A[XLEN-1] & ((funct3 == MDU_MULH) | (funct3 == MDU_MULHSU) |
                                 (funct3 == MDU_DIV)  | (funct3 == MDU_REM));
    assign sign_b = B[XLEN-1] & ((funct3 == MDU_MULH) | (funct3 == MDU_DIV) |
                                 (funct3 == MDU_REM));
    assign mag_a  = magnitude(A, sign_a);
    assign mag_b  = magnitude(B, sign_b);

    assign div_zero = funct3[2] & (B == '0);
    assign div_ovf  = ((funct3 == MDU_DIV) | (funct3 == MDU_REM)) &
                      (A == 32'h8000_0000) & (B == 32'hFFFF_FFFF);
`ifdef MDU_EARLY_OUT_EN
    assign early = (~funct3[2] & ((A == '0) | (B == '0))) |
                   (funct3[2] & ~div_zero & (mag_a < mag_b));
`else
    assign early = 1'b0;
`endif
    assign special = div_zero | div_ovf | early;

    // Result for operations that complete directly from IDLE
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        special_c = '0;
        if (div_zero)
            special_c = funct3[1] ? A : '1;
        else if (div_ovf)
            special_c = funct3[1] ? '0 : 32'h8000_0000;
        else if (early)
            special_c = (funct3[2] & funct3[1]) ? A : '0;
    end

    // Adder operands: shift-add for multiply, trial subtract for divide
    always_comb begin
        add_sub = op[2];
        if (op[2]) begin
            add_a = {hi, lo[XLEN-1]};
            add_b = {1'b0, mb};
        end else begin
            add_a = {1'b0, hi};
            add_b = lo[0] ? {1'b0, mb} : 33'd0;
        end
    end

    mdu_seq_addsub33 u_addsub (
        .a     (add_a),
        .b     (add_b),
        .sub   (add_sub),
        .sum   (add_sum),
        .carry (add_carry)
    );

    // Sign fix-up and result selection
    always_comb begin
        fix_c = lo;
        case (op)
            MDU_MUL:                        fix_c = lo;
            MDU_MULH, MDU_MULHSU, MDU_MULHU:
                // High half of the negated 64-bit product
                fix_c = neg_res ? (~hi + {{(XLEN-1){1'b0}}, (lo == '0)}) : hi;
            MDU_DIV, MDU_DIVU:              fix_c = neg_res ? (~lo + 1'b1) : lo;
            default:                        fix_c = neg_res ? (~hi + 1'b1) : hi;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) state <= MDU_IDLE;
        else       state <= next_state;
    end

    // Next-state and status outputs
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            MDU_IDLE: if (start) next_state = special ? MDU_DONE : MDU_CALC;
            MDU_CALC: begin
                busy = 1'b1;
                if (cnt == MDU_LAST_CNT) next_state = MDU_FIX;
            end
            MDU_FIX: begin
                busy       = 1'b1;
                next_state = MDU_DONE;
            end
            default: begin
                done       = 1'b1;
                next_state = MDU_IDLE;
            end
        endcase
        stall = ((state == MDU_IDLE) & start) | busy;
    end

    // Datapath: operand latch, per-bit iteration, result write
    always_ff @(posedge clk) begin
        if (reset) begin
            op      <= '0;
            cnt     <= '0;
            mb      <= '0;
            hi      <= '0;
            lo      <= '0;
            neg_res <= 1'b0;
            C       <= '0;
        end else begin
            case (state)
                MDU_IDLE: if (start) begin
                    op      <= funct3;
                    mb      <= mag_b;
                    hi      <= '0;
                    lo      <= mag_a;
                    cnt     <= '0;
                    neg_res <= (funct3[2] & funct3[1]) ? sign_a : (sign_a ^ sign_b);
                    if (special) C <= special_c;
                end
                MDU_CALC: begin
                    cnt <= cnt + 1'b1;
                    if (op[2]) begin
                        if (add_carry) begin
                            hi <= add_sum[XLEN-1:0];
                            lo <= {lo[XLEN-2:0], 1'b1};
                        end else begin
                            hi <= {hi[XLEN-2:0], lo[XLEN-1]};
                            lo <= {lo[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        hi <= add_sum[32:1];
                        lo <= {add_sum[0], lo[XLEN-1:1]};
                    end
                end
                MDU_FIX: C <= fix_c;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// Directed self-checking bench for mdu_seq.
// Honours MDU_EARLY_OUT_EN for the early-out latency expectation.
module tb_mdu_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] A, B;
    logic [31:0] C;
    logic        busy, done, stall;

    int checks = 0;
    int errors = 0;
    int done_count = 0;

    mdu_seq dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .funct3 (funct3),
        .A      (A),
        .B      (B),
        .C      (C),
        .busy   (busy),
        .done   (done),
        .stall  (stall)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_count++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Assumes inputs were just set; counts edges (inclusive of the sampling edge)
    // until done, and cycles with stall high before done.
    task automatic wait_done(output int lat, output int stall_n);
        #1;
        stall_n = (stall === 1'b1) ? 1 : 0;
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            lat++;
            if (done === 1'b1) break;
            if (stall === 1'b1) stall_n++;
        end
        if (done !== 1'b1) lat = -1;
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_c, input int exp_lat);
        int lat, stall_n;
        funct3 = op; A = a; B = b; start = 1'b1;
        wait_done(lat, stall_n);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_c"}, C, exp_c);
        check({tag, "_stall_cycles"}, stall_n, exp_lat);
        check({tag, "_done_stall"}, {30'd0, busy, stall}, 32'd0);
        start = 1'b0;
        A = 32'hDEAD_BEEF; B = 32'h0BAD_F00D;
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int lat, stall_n;
        reset = 1'b1; start = 1'b0; funct3 = 3'b000; A = '0; B = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {C[29:0], busy, done}, 32'd0);
        check("reset_stall", {31'd0, stall}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Normal multiply path
        run_op("mul_neg",   3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
        run_op("mulhu",     3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
        run_op("mulh",      3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34);
        run_op("mulhsu",    3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 34);

        // Normal divide path
        run_op("div_neg",   3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
        run_op("rem_neg",   3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
        run_op("divu",      3'b101, 32'd100,       32'd7, 32'd14,        34);
        run_op("remu",      3'b111, 32'd100,       32'd7, 32'd2,         34);

        // Reset in the middle of CALC (cnt == 10)
        funct3 = 3'b000; A = 32'd9; B = 32'd9; start = 1'b1;
        repeat (11) begin @(posedge clk); #1; end
        check("mid_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        check("abort_state", {C[29:0], busy, done}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("abort_no_done", {31'd0, done}, 32'd0);
        run_op("mul_after_reset", 3'b000, 32'd3, 32'd5, 32'd15, 34);

        // Special cases complete straight from IDLE
        run_op("divu_by0",  3'b101, 32'h1234,      32'd0,         32'hFFFF_FFFF, 1);
        run_op("rem_by0",   3'b110, 32'h1234,      32'd0,         32'h0000_1234, 1);
        run_op("div_ovf",   3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf",   3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);

        // Start held through DONE; second instruction issued in the done cycle
        done_count = 0;
        funct3 = 3'b000; A = 32'd3; B = 32'd5; start = 1'b1;
        wait_done(lat, stall_n);
        check("b2b_first_lat", lat, 34);
        check("b2b_first_c", C, 32'd15);
        A = 32'd2; B = 32'd2;
        @(posedge clk); #1;
        check("b2b_idle_stall", {30'd0, done, stall}, 32'd1);
        wait_done(lat, stall_n);
        check("b2b_second_lat", lat, 34);
        check("b2b_second_c", C, 32'd4);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("b2b_done_pulses", done_count, 2);
        check("b2b_c_held", C, 32'd4);

        // Early-out candidate: small dividend
`ifdef MDU_EARLY_OUT_EN
        run_op("divu_small", 3'b101, 32'd3, 32'd10, 32'd0, 1);
        run_op("remu_small", 3'b111, 32'd3, 32'd10, 32'd3, 1);
`else
        run_op("divu_small", 3'b101, 32'd3, 32'd10, 32'd0, 34);
        run_op("remu_small", 3'b111, 32'd3, 32'd10, 32'd3, 34);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
